image_norm_pipe: RTL and testbench

IMAGE_NORM_PIPE -- requirements
Module: image_norm_pipe

---
 rtl/img_norm_pkg.sv | 30 +++
 rtl/norm_lane.sv | 66 ++++++
 rtl/image_norm_pipe.sv | 172 +++++++++++++++++
 tb/tb_image_norm_pipe.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_norm_pkg.sv
// Shared types, constants and the output saturation helper for the image normalisation pipe.
package img_norm_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      FLUSH  = 2'd2
   } state_e;

   localparam int unsigned SCALE_W  = 16;
   localparam int unsigned SAT_IN_W = 64;

   // Clamp a sign-extended value to the signed range of a 'width'-bit result.
   function automatic logic signed [SAT_IN_W-1:0] saturate(
      input logic signed [SAT_IN_W-1:0] value,
      input int unsigned                width
   );
      logic signed [SAT_IN_W-1:0] hi;
      logic signed [SAT_IN_W-1:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (value > hi) begin
         return hi;
      end else if (value < lo) begin
         return lo;
      end
      return value;
   endfunction

endpackage

// File: rtl/norm_lane.sv
// One channel of the normaliser: stage 1 subtracts the mean, stage 2 scales, shifts and saturates.
// IMG_NORM_SAT_CNT_EN adds a saturation flag for the value entering stage 2.
module norm_lane
   import img_norm_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned OUT_WIDTH  = 8,
   parameter int unsigned FRAC_BITS  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_s1,
   input  logic                  load_s2,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [DATA_WIDTH-1:0] mean,
   input  logic [SCALE_W-1:0]    scale,
   output logic [OUT_WIDTH-1:0]  out_data
`ifdef IMG_NORM_SAT_CNT_EN
   ,
   output logic                  sat_next
`endif
);

   localparam int unsigned DIFF_W = DATA_WIDTH + 1;
   // One spare bit keeps the unsigned scale positive once treated as signed.
   localparam int unsigned PROD_W = DIFF_W + SCALE_W + 1;

   logic signed [DIFF_W-1:0]    diff_d;
   logic signed [DIFF_W-1:0]    diff_q;
   logic signed [PROD_W-1:0]    diff_ext;
   logic signed [PROD_W-1:0]    scale_ext;
   logic signed [PROD_W-1:0]    prod;
   logic signed [PROD_W-1:0]    shifted;
   logic signed [SAT_IN_W-1:0]  wide;
   logic signed [OUT_WIDTH-1:0] out_d;
   logic        [OUT_WIDTH-1:0] out_q;

   assign diff_d    = $signed({1'b0, in_data}) - $signed({1'b0, mean});
   assign diff_ext  = {{(PROD_W - DIFF_W){diff_q[DIFF_W-1]}}, diff_q};
   assign scale_ext = {{(PROD_W - SCALE_W){1'b0}}, scale};
   assign prod      = diff_ext * scale_ext;
   assign shifted   = prod >>> FRAC_BITS;
   assign wide      = {{(SAT_IN_W - PROD_W){shifted[PROD_W-1]}}, shifted};
   assign out_d     = OUT_WIDTH'(saturate(wide, OUT_WIDTH));

`ifdef IMG_NORM_SAT_CNT_EN
   assign sat_next = (SAT_IN_W'(out_d) != wide);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         diff_q <= '0;
         out_q  <= '0;
      end else begin
         if (load_s1) begin
            diff_q <= diff_d;
         end
         if (load_s2) begin
            out_q <= out_d;
         end
      end
   end

   assign out_data = out_q;

endmodule

// File: rtl/image_norm_pipe.sv
// Per-channel (in - mean) * scale normaliser with frame FSM and AXI-stream style handshake.
// Define IMG_NORM_SAT_CNT_EN to build the saturated-pixel counter behind sat_count.
module image_norm_pipe
   import img_norm_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned CHANNELS     = 3,
   parameter int unsigned OUT_WIDTH    = 8,
   parameter int unsigned FRAC_BITS    = 8,
   parameter int unsigned FRAME_PIXELS = 1024,
   localparam int unsigned CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           enable,
   input  logic                           frame_start,
   input  logic                           cfg_wr,
   input  logic [CH_W-1:0]                cfg_ch,
   input  logic [DATA_WIDTH-1:0]          cfg_mean,
   input  logic [SCALE_W-1:0]             cfg_scale,
   input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                           s_axis_tvalid,
   output logic                           s_axis_tready,
   output logic [CHANNELS*OUT_WIDTH-1:0]  m_axis_tdata,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic                           m_axis_tlast,
   output logic                           busy,
   output logic [15:0]                    sat_count
);

   localparam int unsigned CNT_W = $clog2(FRAME_PIXELS + 1);
   localparam logic [SCALE_W-1:0] SCALE_ONE = SCALE_W'(32'd1 << FRAC_BITS);

   state_e                  state_q;
   logic [CNT_W-1:0]        pix_cnt_q;
   logic                    advance;
   logic                    accept;
   logic                    last_pix;
   logic                    start_go;
   logic                    s1_valid_q;
   logic                    s1_last_q;
   logic                    out_valid_q;
   logic                    out_last_q;

   logic [DATA_WIDTH-1:0]   mean_stg_q  [CHANNELS];
   logic [SCALE_W-1:0]      scale_stg_q [CHANNELS];
   logic [DATA_WIDTH-1:0]   mean_act_q  [CHANNELS];
   logic [SCALE_W-1:0]      scale_act_q [CHANNELS];

   assign advance       = !out_valid_q || m_axis_tready;
   assign s_axis_tready = (state_q == ACTIVE) && advance;
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign last_pix      = accept && (pix_cnt_q == CNT_W'(FRAME_PIXELS - 1));
   assign start_go      = (state_q == IDLE) && frame_start && enable;
   assign busy          = (state_q != IDLE);
   assign m_axis_tvalid = out_valid_q;
   assign m_axis_tlast  = out_last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pix_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_go) begin
                  state_q   <= ACTIVE;
                  pix_cnt_q <= '0;
               end
            end
            ACTIVE: begin
               if (accept) begin
                  pix_cnt_q <= pix_cnt_q + CNT_W'(1);
               end
               // A completing pixel wins over a simultaneous enable drop.
               if (last_pix || !enable) begin
                  state_q <= FLUSH;
               end
            end
            FLUSH: begin
               if (!s1_valid_q && !out_valid_q) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Staging is writable at any time; the active copy only changes at frame start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < CHANNELS; c++) begin
            mean_stg_q[c]  <= '0;
            scale_stg_q[c] <= SCALE_ONE;
            mean_act_q[c]  <= '0;
            scale_act_q[c] <= SCALE_ONE;
         end
      end else begin
         if (cfg_wr && (32'(cfg_ch) < CHANNELS)) begin
            mean_stg_q[cfg_ch]  <= cfg_mean;
            scale_stg_q[cfg_ch] <= cfg_scale;
         end
         if (start_go) begin
            for (int c = 0; c < CHANNELS; c++) begin
               mean_act_q[c]  <= mean_stg_q[c];
               scale_act_q[c] <= scale_stg_q[c];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else if (advance) begin
         s1_valid_q  <= accept;
         s1_last_q   <= last_pix;
         out_valid_q <= s1_valid_q;
         out_last_q  <= s1_last_q;
      end
   end

`ifdef IMG_NORM_SAT_CNT_EN
   logic [CHANNELS-1:0] lane_sat;
`endif

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      norm_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .OUT_WIDTH  (OUT_WIDTH),
         .FRAC_BITS  (FRAC_BITS)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .load_s1  (advance && accept),
         .load_s2  (advance && s1_valid_q),
         .in_data  (s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH]),
         .mean     (mean_act_q[g]),
         .scale    (scale_act_q[g]),
         .out_data (m_axis_tdata[g*OUT_WIDTH +: OUT_WIDTH])
`ifdef IMG_NORM_SAT_CNT_EN
         ,
         .sat_next (lane_sat[g])
`endif
      );
   end

`ifdef IMG_NORM_SAT_CNT_EN
   logic [15:0] sat_cnt_q;

   // Counted as the pixel enters the output register, so it tracks emitted pixels.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_cnt_q <= '0;
      end else if (start_go) begin
         sat_cnt_q <= '0;
      end else if (advance && s1_valid_q && (|lane_sat) && (sat_cnt_q != 16'hFFFF)) begin
         sat_cnt_q <= sat_cnt_q + 16'd1;
      end
   end

   assign sat_count = sat_cnt_q;
`else
   assign sat_count = '0;
`endif

endmodule

// File: tb/tb_image_norm_pipe.sv
// Directed self-checking bench for image_norm_pipe (16-pixel frames plus a 4-pixel instance).
module tb_image_norm_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        enable = 1'b0, frame_start = 1'b0, cfg_wr = 1'b0;
   logic [1:0]  cfg_ch = '0;
   logic [7:0]  cfg_mean = '0;
   logic [15:0] cfg_scale = '0;
   logic [23:0] s_tdata = '0;
   logic        s_tvalid = 1'b0, s_tready;
   logic [23:0] m_tdata;
   logic        m_tvalid, m_tlast, busy;
   logic        m_tready = 1'b1;
   logic [15:0] sat_count;

   logic        enable4 = 1'b0, frame_start4 = 1'b0, s_tvalid4 = 1'b0, s_tready4;
   logic [23:0] s_tdata4 = '0, m_tdata4;
   logic        m_tvalid4, m_tlast4, busy4;
   logic        m_tready4 = 1'b1;
   logic [15:0] sat_count4;

   image_norm_pipe #(.FRAME_PIXELS(16)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start),
      .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_mean(cfg_mean), .cfg_scale(cfg_scale),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tlast(m_tlast), .busy(busy), .sat_count(sat_count)
   );

   image_norm_pipe #(.FRAME_PIXELS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .enable(enable4), .frame_start(frame_start4),
      .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_mean(cfg_mean), .cfg_scale(cfg_scale),
      .s_axis_tdata(s_tdata4), .s_axis_tvalid(s_tvalid4), .s_axis_tready(s_tready4),
      .m_axis_tdata(m_tdata4), .m_axis_tvalid(m_tvalid4), .m_axis_tready(m_tready4),
      .m_axis_tlast(m_tlast4), .busy(busy4), .sat_count(sat_count4)
   );

   int errors = 0;
   int checks = 0;

   logic [23:0] out_q[$];
   logic        last_q[$];
   logic [23:0] out4_q[$];
   logic        last4_q[$];

   always @(posedge clk) begin
      if (m_tvalid && m_tready) begin
         out_q.push_back(m_tdata);
         last_q.push_back(m_tlast);
      end
      if (m_tvalid4 && m_tready4) begin
         out4_q.push_back(m_tdata4);
         last4_q.push_back(m_tlast4);
      end
   end

   // Output must not move while stalled.
   logic        hold_v = 1'b0;
   logic [23:0] hold_d = '0;
   logic        hold_l = 1'b0;
   always @(posedge clk) begin
      if (hold_v) begin
         checks++;
         assert (m_tvalid === 1'b1 && m_tdata === hold_d && m_tlast === hold_l) else begin
            errors++;
            $error("FAIL stall_hold: observed=%h/v%b/l%b expected=%h/v1/l%b",
                   m_tdata, m_tvalid, m_tlast, hold_d, hold_l);
         end
      end
      hold_v = m_tvalid && !m_tready;
      hold_d = m_tdata;
      hold_l = m_tlast;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_all(input logic [7:0] mean, input logic [15:0] scale);
      for (int c = 0; c < 3; c++) begin
         cfg_wr = 1'b1; cfg_ch = 2'(c); cfg_mean = mean; cfg_scale = scale;
         tick();
      end
      cfg_wr = 1'b0;
   endtask

   task automatic start_frame();
      enable = 1'b1; frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 60) begin
         tick();
         n++;
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   logic [23:0] pix_a [5];
   logic [23:0] exp_a [5];
   logic [23:0] exp_b;
   logic [7:0]  kk;
   logic        rdy [8];
   int          acc4, idx, cyc, n_last;
   logic        acc;

   initial begin
      pix_a = '{24'h0080C8, 24'h817FFF, 24'h1E140A, 24'h808080, 24'hFA0081};
      exp_a = '{24'h800048, 24'h01FF7F, 24'h9E948A, 24'h000000, 24'h7A8001};

      // Reset state
      #12;
      chk("rst_tready", 32'(s_tready), 32'd0);
      chk("rst_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_tlast", 32'(m_tlast), 32'd0);
      chk("rst_tdata", 32'(m_tdata), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sat", 32'(sat_count), 32'd0);
      rst_n = 1'b1;
      tick();

      // 4-pixel frame, continuous valid; second frame_start during FLUSH is ignored
      enable4 = 1'b1; frame_start4 = 1'b1;
      tick();
      frame_start4 = 1'b0;
      acc4 = 0;
      for (int c = 0; c < 8; c++) begin
         s_tvalid4 = 1'b1;
         s_tdata4 = {3{8'(acc4 + 1)}};
         frame_start4 = (c == 4);
         @(negedge clk);
         rdy[c] = s_tready4;
         if (s_tvalid4 && s_tready4) acc4++;
         tick();
      end
      frame_start4 = 1'b0; s_tvalid4 = 1'b0;
      chk("f4_accepts", 32'(acc4), 32'd4);
      chk("f4_tready_after4", 32'(rdy[4]), 32'd0);
      chk("f4_tready_4th", 32'(rdy[3]), 32'd1);
      chk("f4_idle_ignored_start", 32'(busy4), 32'd0);
      chk("f4_out_count", 32'(out4_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < out4_q.size(); i++) begin
         chk($sformatf("f4_data%0d", i), 32'(out4_q[i]), 32'({3{8'(i + 1)}}));
         chk($sformatf("f4_last%0d", i), 32'(last4_q[i]), 32'(i == 3));
      end

      // Frame A: unity scale, mean 128; mid-frame cfg write; abort after 5 pixels
      cfg_all(8'd128, 16'h0100);
      cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_mean = 8'd77; cfg_scale = 16'h0300;
      tick();
      cfg_wr = 1'b0;
      out_q.delete(); last_q.delete();
      start_frame();
      m_tready = 1'b1;
      s_tvalid = 1'b1; s_tdata = pix_a[0];
      tick();
      chk("lat_not_yet", 32'(m_tvalid), 32'd0);
      s_tdata = pix_a[1];
      tick();
      chk("lat_valid", 32'(m_tvalid), 32'd1);
      chk("unity_pix0", 32'(m_tdata), 32'(exp_a[0]));
      s_tdata = pix_a[2];
      cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_mean = 8'd10; cfg_scale = 16'h0100;
      tick();
      cfg_wr = 1'b0;
      s_tdata = pix_a[3];
      tick();
      s_tdata = pix_a[4];
      tick();
      s_tvalid = 1'b0; enable = 1'b0;
      tick();
      chk("abort_flush_busy", 32'(busy), 32'd1);
      wait_idle("abort_idle");
      chk("a_out_count", 32'(out_q.size()), 32'd5);
      n_last = 0;
      for (int i = 0; i < out_q.size(); i++) begin
         if (i < 5) chk($sformatf("a_data%0d", i), 32'(out_q[i]), 32'(exp_a[i]));
         if (last_q[i]) n_last++;
      end
      chk("a_no_tlast", 32'(n_last), 32'd0);

      // Frame B: 16 pixels, mean ch0=10 now active, m_tready toggling
      out_q.delete(); last_q.delete();
      start_frame();
      idx = 0; cyc = 0;
      while (idx < 16 && cyc < 200) begin
         kk = 8'(idx);
         s_tdata = {8'(8'd128 - kk), 8'(8'd128 + kk), 8'(8'd10 + kk)};
         s_tvalid = 1'b1;
         m_tready = (cyc % 2 == 0);
         @(negedge clk);
         acc = s_tvalid && s_tready;
         tick();
         if (acc) idx++;
         cyc++;
      end
      chk("b_all_accepted", 32'(idx), 32'd16);
      s_tvalid = 1'b0;
      m_tready = 1'b0;
      tick();
      m_tready = 1'b1;
      wait_idle("b_idle");
      chk("b_out_count", 32'(out_q.size()), 32'd16);
      for (int i = 0; i < 16 && i < out_q.size(); i++) begin
         kk = 8'(i);
         exp_b = {8'(8'd0 - kk), kk, kk};
         chk($sformatf("b_data%0d", i), 32'(out_q[i]), 32'(exp_b));
         chk($sformatf("b_last%0d", i), 32'(last_q[i]), 32'(i == 15));
      end

      // Frame C: saturation at scale 2.0
      cfg_all(8'd0, 16'h0200);
      out_q.delete(); last_q.delete();
      start_frame();
      s_tvalid = 1'b1; s_tdata = 24'hFFFFFF;
      tick();
      s_tvalid = 1'b0;
      tick(); tick(); tick();
      chk("sat_out_count", 32'(out_q.size()), 32'd1);
      if (out_q.size() > 0) chk("sat_data", 32'(out_q[0]), 32'h7F7F7F);
`ifdef IMG_NORM_SAT_CNT_EN
      chk("sat_count", 32'(sat_count), 32'd1);
`else
      chk("sat_count", 32'(sat_count), 32'd0);
`endif
      enable = 1'b0;
      wait_idle("sat_idle");

      // Frame D: reset pulse mid-frame
      out_q.delete(); last_q.delete();
      start_frame();
      s_tvalid = 1'b1; s_tdata = 24'h102030;
      tick();
      s_tdata = 24'h405060;
      tick();
      chk("d_pre_valid", 32'(m_tvalid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("d_rst_tvalid", 32'(m_tvalid), 32'd0);
      chk("d_rst_busy", 32'(busy), 32'd0);
      chk("d_rst_tready", 32'(s_tready), 32'd0);
      chk("d_rst_sat", 32'(sat_count), 32'd0);
      s_tvalid = 1'b0;
      #3 rst_n = 1'b1;
      tick(); tick(); tick(); tick();
      chk("d_no_output", 32'(out_q.size()), 32'd0);
      chk("d_still_idle", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
